// File: rtl/lb_reader.sv
// Display-side sprite line-buffer reader: streams one buffer to palette RAM, one pixel per 4-cycle slot.
// Optional macro LB_READ_CLEAR_EN enables the clear-after-read (0xFFF) write in PH2.
`timescale 1ns/1ps
module lb_reader #(
   parameter int unsigned LINE_PIXELS = 192
) (
   input  logic        CLK_24M,
   input  logic        RESET,
   input  logic        H_START,
   input  logic        LINE_PARITY,
   input  logic [7:0]  START_ADDR,
   input  logic [11:0] LB_DATA_A,
   input  logic [11:0] LB_DATA_B,
   output logic        LB_SEL,
   output logic        LB_CK,
   output logic        LB_LOAD,
   output logic [7:0]  LB_ADDR_LOAD,
   output logic        LB_WE,
   output logic        LB_CLEARING,
   output logic [11:0] PAL_ADDR,
   output logic        PAL_VALID,
   output logic        LINE_DONE
);

   localparam logic [7:0]  LAST_PIX = 8'(LINE_PIXELS - 1);
   localparam logic [11:0] BACKDROP = 12'hFFF;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  ph_q, ph_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sel_q, sel_d;
   logic        ck_q, ck_d;
   logic        load_q, load_d;
   logic [7:0]  addr_load_q, addr_load_d;
   logic        we_q, we_d;
   logic        clr_q, clr_d;
   logic [11:0] pal_addr_q, pal_addr_d;
   logic        pal_valid_q, pal_valid_d;
   logic        line_done_q, line_done_d;

   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      addr_load_d = addr_load_q;
      pal_addr_d  = pal_addr_q;
      pal_valid_d = pal_valid_q;
      line_done_d = 1'b0;
      ck_d        = 1'b0;
      load_d      = 1'b1;
      we_d        = 1'b1;
      clr_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (H_START) begin
               state_d     = S_LOAD;
               ph_d        = 2'd0;
               sel_d       = LINE_PARITY;
               addr_load_d = START_ADDR;
            end
         end
         S_LOAD: begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
               state_d = S_RUN;
               cnt_d   = 8'd0;
            end
         end
         S_RUN: begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd1) begin
               pal_addr_d  = sel_q ? LB_DATA_B : LB_DATA_A;
               pal_valid_d = 1'b1;
            end
            if (ph_q == 2'd3) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LAST_PIX) begin
                  state_d     = S_DONE;
                  line_done_d = 1'b1;
                  pal_valid_d = 1'b0;
                  pal_addr_d  = BACKDROP;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            ph_d    = 2'd0;
            cnt_d   = 8'd0;
         end
      endcase

      // Buffer controls are registered, so derive them from the state being entered.
      case (state_d)
         S_LOAD: begin
            load_d = 1'b0;
            ck_d   = (ph_d == 2'd3);
         end
         S_RUN: begin
            ck_d = (ph_d == 2'd3);
`ifdef LB_READ_CLEAR_EN
            if (ph_d == 2'd2) begin
               we_d  = 1'b0;
               clr_d = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_24M or posedge RESET) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         ph_q        <= 2'd0;
         cnt_q       <= 8'd0;
         sel_q       <= 1'b0;
         ck_q        <= 1'b0;
         load_q      <= 1'b1;
         addr_load_q <= 8'd0;
         we_q        <= 1'b1;
         clr_q       <= 1'b0;
         pal_addr_q  <= BACKDROP;
         pal_valid_q <= 1'b0;
         line_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         ck_q        <= ck_d;
         load_q      <= load_d;
         addr_load_q <= addr_load_d;
         we_q        <= we_d;
         clr_q       <= clr_d;
         pal_addr_q  <= pal_addr_d;
         pal_valid_q <= pal_valid_d;
         line_done_q <= line_done_d;
      end
   end

   assign LB_SEL       = sel_q;
   assign LB_CK        = ck_q;
   assign LB_LOAD      = load_q;
   assign LB_ADDR_LOAD = addr_load_q;
   assign LB_WE        = we_q;
   assign LB_CLEARING  = clr_q;
   assign PAL_ADDR     = pal_addr_q;
   assign PAL_VALID    = pal_valid_q;
   assign LINE_DONE    = line_done_q;

endmodule

// File: tb/tb_lb_reader.sv
// Directed bench for lb_reader with a line-buffer model (8-bit address counter plus two 256x12 buffers).
`timescale 1ns/1ps
module tb_lb_reader;

   localparam int unsigned LINE_PIXELS   = 4;
   localparam logic [7:0]  START_DEFAULT = 8'd0;
`ifdef LB_READ_CLEAR_EN
   localparam int EXP_WE_PULSES = 4;
`else
   localparam int EXP_WE_PULSES = 0;
`endif

   logic        CLK_24M = 1'b0;
   logic        RESET = 1'b1;
   logic        H_START = 1'b0;
   logic        LINE_PARITY = 1'b0;
   logic [7:0]  START_ADDR = 8'd0;
   logic [11:0] LB_DATA_A, LB_DATA_B;
   logic        LB_SEL, LB_CK, LB_LOAD, LB_WE, LB_CLEARING, PAL_VALID, LINE_DONE;
   logic [7:0]  LB_ADDR_LOAD;
   logic [11:0] PAL_ADDR;

   logic [11:0] mem_a [256];
   logic [11:0] mem_b [256];
   logic [7:0]  bcnt = 8'd0;
   logic [11:0] saved;

   int n_tests = 0;
   int n_fail  = 0;

   lb_reader #(.LINE_PIXELS(LINE_PIXELS)) dut (
      .CLK_24M(CLK_24M), .RESET(RESET), .H_START(H_START), .LINE_PARITY(LINE_PARITY),
      .START_ADDR(START_ADDR), .LB_DATA_A(LB_DATA_A), .LB_DATA_B(LB_DATA_B),
      .LB_SEL(LB_SEL), .LB_CK(LB_CK), .LB_LOAD(LB_LOAD), .LB_ADDR_LOAD(LB_ADDR_LOAD),
      .LB_WE(LB_WE), .LB_CLEARING(LB_CLEARING), .PAL_ADDR(PAL_ADDR),
      .PAL_VALID(PAL_VALID), .LINE_DONE(LINE_DONE)
   );

   always #5 CLK_24M = ~CLK_24M;

   // External buffer address counter and transparent read latch.
   always @(posedge LB_CK) bcnt <= LB_LOAD ? bcnt + 8'd1 : LB_ADDR_LOAD;
   assign LB_DATA_A = mem_a[bcnt];
   assign LB_DATA_B = mem_b[bcnt];

   always @(negedge CLK_24M) begin
      if (!LB_WE) begin
         if (LB_SEL) mem_b[bcnt] = LB_CLEARING ? 12'hFFF : 12'h000;
         else        mem_a[bcnt] = LB_CLEARING ? 12'hFFF : 12'h000;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full line; c is the cycle index with edge 0 sampling H_START.
   task automatic run_line(input logic [7:0] sa, input logic par,
                           input logic [11:0] e0, input logic [11:0] e1,
                           input logic [11:0] e2, input logic [11:0] e3,
                           input bit extra_hs, input bit flip_par);
      logic [11:0] exp_pix [4];
      int done_cnt, ck_cnt, we_cnt, we_bad, clr_bad;
      exp_pix[0] = e0; exp_pix[1] = e1; exp_pix[2] = e2; exp_pix[3] = e3;
      done_cnt = 0; ck_cnt = 0; we_cnt = 0; we_bad = 0; clr_bad = 0;
      @(negedge CLK_24M);
      H_START = 1'b1; LINE_PARITY = par; START_ADDR = sa;
      @(posedge CLK_24M);
      #1 H_START = 1'b0; START_ADDR = 8'h5A;
      for (int c = 0; c < 26; c++) begin
         @(negedge CLK_24M);
         if (LINE_DONE) done_cnt++;
         if (LB_CK) ck_cnt++;
         if (!LB_WE) begin
            we_cnt++;
            if (c < 4 || ((c - 4) % 4) != 2) we_bad++;
         end
         if (LB_CLEARING !== !LB_WE) clr_bad++;
         if (c == 0) begin
            check("sel_latched", int'(LB_SEL), int'(par));
            check("addr_load", int'(LB_ADDR_LOAD), int'(sa));
            check("load_low", int'(LB_LOAD), 0);
         end
         if (c == 5) check("valid_before_pix0", int'(PAL_VALID), 0);
         if (c >= 6 && c <= 18 && ((c - 6) % 4) == 0) begin
            check($sformatf("pal_pix%0d", (c - 6) / 4), int'(PAL_ADDR), int'(exp_pix[(c - 6) / 4]));
            check($sformatf("valid_pix%0d", (c - 6) / 4), int'(PAL_VALID), 1);
         end
         if (c == 20) begin
            check("line_done", int'(LINE_DONE), 1);
            check("pal_backdrop", int'(PAL_ADDR), 12'hFFF);
            check("valid_done", int'(PAL_VALID), 0);
         end
         if (flip_par && c == 8) LINE_PARITY = ~par;
         if (extra_hs && (c == 8 || c == 20)) H_START = 1'b1;
         if (c == 9 || c == 21) H_START = 1'b0;
      end
      check("done_pulses", done_cnt, 1);
      check("ck_pulses", ck_cnt, 5);
      check("we_pulses", we_cnt, EXP_WE_PULSES);
      check("we_phase", we_bad, 0);
      check("clearing_tracks_we", clr_bad, 0);
      LINE_PARITY = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel"}, int'(LB_SEL), 0);
      check({tag, "_ck"}, int'(LB_CK), 0);
      check({tag, "_load"}, int'(LB_LOAD), 1);
      check({tag, "_addr_load"}, int'(LB_ADDR_LOAD), 0);
      check({tag, "_we"}, int'(LB_WE), 1);
      check({tag, "_clearing"}, int'(LB_CLEARING), 0);
      check({tag, "_pal"}, int'(PAL_ADDR), 12'hFFF);
      check({tag, "_valid"}, int'(PAL_VALID), 0);
      check({tag, "_done"}, int'(LINE_DONE), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 12'h000;
         mem_b[i] = 12'h000;
      end
      repeat (3) @(posedge CLK_24M);
      #1 check_reset_outputs("rst");
      @(negedge CLK_24M) RESET = 1'b0;
      repeat (2) @(negedge CLK_24M);

      // Basic read from buffer A, then clear-after-read result
      mem_a[8'h10] = 12'h123; mem_a[8'h11] = 12'h456;
      mem_a[8'h12] = 12'h789; mem_a[8'h13] = 12'hABC;
      run_line(8'h10, 1'b0, 12'h123, 12'h456, 12'h789, 12'hABC, 1'b0, 1'b0);
`ifdef LB_READ_CLEAR_EN
      check("clr_10", int'(mem_a[8'h10]), 12'hFFF);
      check("clr_11", int'(mem_a[8'h11]), 12'hFFF);
      check("clr_12", int'(mem_a[8'h12]), 12'hFFF);
      check("clr_13", int'(mem_a[8'h13]), 12'hFFF);
`else
      check("keep_10", int'(mem_a[8'h10]), 12'h123);
      check("keep_11", int'(mem_a[8'h11]), 12'h456);
      check("keep_12", int'(mem_a[8'h12]), 12'h789);
      check("keep_13", int'(mem_a[8'h13]), 12'hABC);
`endif

      // Buffer B select with mid-line parity change
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 12'h111;
         mem_b[i] = 12'h222;
      end
      run_line(8'h40, 1'b1, 12'h222, 12'h222, 12'h222, 12'h222, 1'b0, 1'b1);

      // Address wrap through 0xFF -> 0x00
      for (int i = 0; i < 256; i++) mem_a[i] = 12'h100 | 12'(i);
      run_line(8'hFE, 1'b0, 12'h1FE, 12'h1FF, 12'h100, 12'h101, 1'b0, 1'b0);

      // H_START during RUN and DONE must be ignored
      for (int i = 0; i < 256; i++) mem_a[i] = 12'h300 | 12'(i);
      run_line(8'h20, 1'b0, 12'h320, 12'h321, 12'h322, 12'h323, 1'b1, 1'b0);

      // Reset asserted in PH2 of slot 1 (cycle 10)
      for (int i = 0; i < 256; i++) mem_a[i] = 12'h500 | 12'(i);
      @(negedge CLK_24M);
      H_START = 1'b1; LINE_PARITY = 1'b1; START_ADDR = 8'h30;
      @(posedge CLK_24M);
      #1 H_START = 1'b0;
      repeat (10) @(posedge CLK_24M);
      #1 check("pre_rst_valid", int'(PAL_VALID), 1);
      saved = mem_b[8'h31];
      RESET = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge CLK_24M);
      check("no_partial_write", int'(mem_b[8'h31]), int'(saved));
      RESET = 1'b0;
      repeat (3) @(negedge CLK_24M);
      check("idle_after_rst_ck", int'(LB_CK), 0);
      run_line(START_DEFAULT, 1'b0, 12'h500, 12'h501, 12'h502, 12'h503, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lb_reader.md
Name: lb_reader

Overview:
- Display-side reader for the sprite line buffers. Sprite rendering writes pixels into one buffer while this block reads the other buffer, one pixel per slot, and sends the 12-bit palette address to palette RAM.
- After each pixel is read, the block writes the backdrop value 0xFFF back to the same location, so the buffer is clean for the next render pass.
- Runs on the 24 MHz master clock. Each pixel slot is four master cycles (one 6 MHz pixel).

Parameters:
- LINE_PIXELS, 192, pixel slots read per line; legal range 1..256.
- START_DEFAULT, 8'd0, START_ADDR value used by the Test Plan benches.

Ports:
- CLK_24M  in  1  master clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- H_START  in  1  one-cycle line-start pulse; sampled only in IDLE.
- LINE_PARITY  in  1  buffer to display for this line; 0 = A, 1 = B.
- START_ADDR  in  8  first buffer address of the line; sampled with H_START.
- LB_DATA_A  in  12  read data from buffer A.
- LB_DATA_B  in  12  read data from buffer B.
- LB_SEL  out  1  latched buffer select, so external logic can route the controls.
- LB_CK  out  1  buffer address-counter clock; rising edge at start of phase 3.
- LB_LOAD  out  1  0 = reload counter from LB_ADDR_LOAD; 1 = increment.
- LB_ADDR_LOAD  out  8  latched START_ADDR.
- LB_WE  out  1  active-low write strobe; 1 = read / latch transparent.
- LB_CLEARING  out  1  forces buffer write data to 0xFFF.
- PAL_ADDR  out  12  registered palette address.
- PAL_VALID  out  1  PAL_ADDR holds a pixel of the current line.
- LINE_DONE  out  1  one-cycle pulse after the last slot.

Behaviour:
- Reset values: LB_SEL=0, LB_CK=0, LB_LOAD=1, LB_ADDR_LOAD=0, LB_WE=1, LB_CLEARING=0, PAL_ADDR=12'hFFF, PAL_VALID=0, LINE_DONE=0. State=IDLE, PH=0, pixel count=0.
- Reset mid-line: all of the above take effect immediately (asynchronous). No partial write follows, because LB_WE returns to 1 at once.
- All outputs are registered.
- States:
  - IDLE → LOAD on an edge with H_START=1. At that edge: latch LINE_PARITY into LB_SEL, latch START_ADDR into LB_ADDR_LOAD, set PH=0.
  - LOAD lasts 4 cycles. LB_LOAD=0 throughout; LB_CK=1 during PH=3 only, which reloads the buffer counter. Then → RUN with count=0.
  - RUN, one slot per pixel:
    - PH0: LB_WE=1, so the buffer latch follows the counter.
    - PH1: LB_WE=1. At the edge ending PH1, PAL_ADDR takes LB_SEL ? LB_DATA_B : LB_DATA_A, and PAL_VALID is set to 1.
    - PH2: LB_WE=0 and LB_CLEARING=1, writing 0xFFF.
    - PH3: LB_WE=1, LB_CLEARING=0, LB_LOAD=1, LB_CK=1, so the counter increments.
    - At the end of PH3: count+1. If count==LINE_PIXELS-1 → DONE.
  - DONE lasts 1 cycle: LINE_DONE=1, PAL_VALID=0, PAL_ADDR=12'hFFF. Then → IDLE.
- Timing, with edge 0 = the edge that samples H_START:
  - Slot k occupies cycles 4+4k .. 7+4k.
  - Pixel k is visible on PAL_ADDR from cycle 6+4k through 9+4k.
  - LINE_DONE is high in cycle 4+4·LINE_PIXELS.
- H_START outside IDLE is ignored, including in the DONE cycle. LINE_PARITY and START_ADDR are ignored except at the accepted H_START edge.
- Address wrap: the buffer counter is 8 bits, so START_ADDR + count wraps modulo 256. The block itself does no range check.
- LB_DATA is sampled only at the end of PH1. Data values are passed through unmodified; 0xFFF is the backdrop palette entry.

Optional Feature:
- Macro LB_READ_CLEAR_EN.
  - Defined: the PH2 clear-after-read write described above.
  - Undefined: LB_WE stays 1 and LB_CLEARING stays 0 at all times. Reads are non-destructive and all other timing is unchanged; buffers must then be cleared elsewhere.

Test Plan:
- Basic read: LINE_PIXELS=4, START_ADDR=8'h10, LINE_PARITY=0, buffer A model holds 0x123/0x456/0x789/0xABC at 0x10..0x13 → PAL_ADDR shows those values from cycles 6/10/14/18, PAL_VALID=1, LINE_DONE in cycle 20, then PAL_ADDR=0xFFF.
- Clear-after-read, macro defined: same line run → model addresses 0x10..0x13 hold 0xFFF; exactly four LB_WE low pulses, each in PH2. Macro undefined: memory unchanged and zero LB_WE pulses.
- Buffer select: LINE_PARITY=1 with LB_DATA_A=0x111 and LB_DATA_B=0x222 → LB_SEL=1, all PAL_ADDR=0x222. A parity change mid-line has no effect.
- Wrap: START_ADDR=8'hFE, LINE_PIXELS=4 → the model counter reads 0xFE, 0xFF, 0x00, 0x01.
- Ignored start: a second H_START at cycle 9 → no restart; exactly LINE_PIXELS slots, one LINE_DONE.
- Reset mid-line: RESET asserted in PH2 of slot 1 → all outputs at reset values within the same cycle, LB_WE=1. A new H_START after release starts a clean line.
